// File: rtl/vga_timing_aot_pkg.sv
// Shared constants and types for the VGA raster timing generator.
// Holds the default 640x480@60 timing, the default look-ahead depth,
// the whole-line/whole-frame helper constants and a position struct.
package vga_timing_aot_pkg;

  localparam int unsigned DEF_H_VISIBLE_AREA = 640;
  localparam int unsigned DEF_H_FRONT_PORCH  = 16;
  localparam int unsigned DEF_H_SYNC_PULSE   = 96;
  localparam int unsigned DEF_H_BACK_PORCH   = 48;
  localparam int unsigned DEF_V_VISIBLE_AREA = 480;
  localparam int unsigned DEF_V_FRONT_PORCH  = 10;
  localparam int unsigned DEF_V_SYNC_PULSE   = 2;
  localparam int unsigned DEF_V_BACK_PORCH   = 33;

  // Depth of the downstream drawing pipeline; default look-ahead.
  localparam int unsigned PIPELINE_STAGES = 2;

  localparam int unsigned DEF_H_WHOLE_LINE = DEF_H_VISIBLE_AREA + DEF_H_FRONT_PORCH
                                           + DEF_H_SYNC_PULSE + DEF_H_BACK_PORCH;
  localparam int unsigned DEF_V_WHOLE_LINE = DEF_V_VISIBLE_AREA + DEF_V_FRONT_PORCH
                                           + DEF_V_SYNC_PULSE + DEF_V_BACK_PORCH;

  localparam int unsigned DEF_H_ADDR_WIDTH = $clog2(DEF_H_WHOLE_LINE);
  localparam int unsigned DEF_V_ADDR_WIDTH = $clog2(DEF_V_WHOLE_LINE);

  typedef struct packed {
    logic [DEF_H_ADDR_WIDTH-1:0] x;
    logic [DEF_V_ADDR_WIDTH-1:0] y;
  } vga_pos_t;

endpackage

// File: rtl/vga_timing_aot_raster_counter.sv
// vga_raster_counter: beam position and frame counter registers.
// Ports: vga_pix_clk (clock), rst (sync, active-high), pix_ce (advance
// enable), sx/sy (current column/row), frame_cnt (completed frames).
module vga_raster_counter
  import vga_timing_aot_pkg::*;
#(
  parameter int unsigned H_WHOLE_LINE = DEF_H_WHOLE_LINE,
  parameter int unsigned V_WHOLE_LINE = DEF_V_WHOLE_LINE,
  parameter int unsigned H_ADDR_WIDTH = $clog2(H_WHOLE_LINE),
  parameter int unsigned V_ADDR_WIDTH = $clog2(V_WHOLE_LINE),
  parameter int unsigned FRAME_CNT_W  = 16
) (
  input  logic                    vga_pix_clk,
  input  logic                    rst,
  input  logic                    pix_ce,
  output logic [H_ADDR_WIDTH-1:0] sx,
  output logic [V_ADDR_WIDTH-1:0] sy,
  output logic [FRAME_CNT_W-1:0]  frame_cnt
);

  localparam logic [H_ADDR_WIDTH-1:0] H_LAST = H_ADDR_WIDTH'(H_WHOLE_LINE - 1);
  localparam logic [V_ADDR_WIDTH-1:0] V_LAST = V_ADDR_WIDTH'(V_WHOLE_LINE - 1);

  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      sx        <= '0;
      sy        <= '0;
      frame_cnt <= '0;
    end else if (pix_ce) begin
      if (sx == H_LAST) begin
        sx <= '0;
        if (sy == V_LAST) begin
          sy        <= '0;
          frame_cnt <= frame_cnt + 1'b1;
        end else begin
          sy <= sy + 1'b1;
        end
      end else begin
        sx <= sx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_timing_aot.sv
// vga_timing_aot: VGA raster timing generator with look-ahead position.
// Ports: vga_pix_clk, rst (sync, active-high), pix_ce (pixel advance);
// sx/sy, display_enabled, hsync, vsync: current beam;
// sx_aot/sy_aot, display_enabled_aot: beam LEAD pixels ahead;
// line_stb_aot, frame_stb_aot, frame_stb: pix_ce-qualified pulses;
// frame_cnt: completed frames (wrapping).
// Only sx/sy/frame_cnt are registered; everything else is decoded
// combinationally so it has zero latency relative to sx/sy.
module vga_timing_aot
  import vga_timing_aot_pkg::*;
#(
  parameter int unsigned H_VISIBLE_AREA = DEF_H_VISIBLE_AREA,
  parameter int unsigned H_FRONT_PORCH  = DEF_H_FRONT_PORCH,
  parameter int unsigned H_SYNC_PULSE   = DEF_H_SYNC_PULSE,
  parameter int unsigned H_BACK_PORCH   = DEF_H_BACK_PORCH,
  parameter int unsigned V_VISIBLE_AREA = DEF_V_VISIBLE_AREA,
  parameter int unsigned V_FRONT_PORCH  = DEF_V_FRONT_PORCH,
  parameter int unsigned V_SYNC_PULSE   = DEF_V_SYNC_PULSE,
  parameter int unsigned V_BACK_PORCH   = DEF_V_BACK_PORCH,
  parameter int unsigned LEAD           = PIPELINE_STAGES,
  parameter logic        HS_POL         = 1'b0,
  parameter logic        VS_POL         = 1'b0,
  parameter int unsigned FRAME_CNT_W    = 16,
  localparam int unsigned H_WHOLE_LINE  = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
  localparam int unsigned V_WHOLE_LINE  = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
  localparam int unsigned H_ADDR_WIDTH  = $clog2(H_WHOLE_LINE),
  localparam int unsigned V_ADDR_WIDTH  = $clog2(V_WHOLE_LINE)
) (
  input  logic                    vga_pix_clk,
  input  logic                    rst,
  input  logic                    pix_ce,
  output logic [H_ADDR_WIDTH-1:0] sx,
  output logic [V_ADDR_WIDTH-1:0] sy,
  output logic                    display_enabled,
  output logic                    hsync,
  output logic                    vsync,
  output logic [H_ADDR_WIDTH-1:0] sx_aot,
  output logic [V_ADDR_WIDTH-1:0] sy_aot,
  output logic                    display_enabled_aot,
  output logic                    line_stb_aot,
  output logic                    frame_stb_aot,
  output logic                    frame_stb,
  output logic [FRAME_CNT_W-1:0]  frame_cnt
);

  if (LEAD >= H_WHOLE_LINE) begin : g_lead_check
    $error("vga_timing_aot: LEAD must be less than H_WHOLE_LINE");
  end

  // One extra bit so sums and window ends never overflow.
  localparam int unsigned HX = H_ADDR_WIDTH + 1;
  localparam int unsigned VX = V_ADDR_WIDTH + 1;

  localparam logic [HX-1:0] H_LAST_X   = HX'(H_WHOLE_LINE - 1);
  localparam logic [HX-1:0] H_WHOLE_X  = HX'(H_WHOLE_LINE);
  localparam logic [HX-1:0] LEAD_X     = HX'(LEAD);
  localparam logic [HX-1:0] H_VIS_X    = HX'(H_VISIBLE_AREA);
  localparam logic [HX-1:0] HS_START_X = HX'(H_VISIBLE_AREA + H_FRONT_PORCH);
  localparam logic [HX-1:0] HS_END_X   = HX'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [VX-1:0] V_VIS_X    = VX'(V_VISIBLE_AREA);
  localparam logic [VX-1:0] VS_START_X = VX'(V_VISIBLE_AREA + V_FRONT_PORCH);
  localparam logic [VX-1:0] VS_END_X   = VX'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);
  localparam logic [V_ADDR_WIDTH-1:0] V_LAST = V_ADDR_WIDTH'(V_WHOLE_LINE - 1);

  vga_raster_counter #(
    .H_WHOLE_LINE (H_WHOLE_LINE),
    .V_WHOLE_LINE (V_WHOLE_LINE),
    .H_ADDR_WIDTH (H_ADDR_WIDTH),
    .V_ADDR_WIDTH (V_ADDR_WIDTH),
    .FRAME_CNT_W  (FRAME_CNT_W)
  ) u_counter (
    .vga_pix_clk (vga_pix_clk),
    .rst         (rst),
    .pix_ce      (pix_ce),
    .sx          (sx),
    .sy          (sy),
    .frame_cnt   (frame_cnt)
  );

  logic [HX-1:0] sx_x;
  logic [HX-1:0] sx_sum;
  logic [HX-1:0] sx_aot_x;
  logic [VX-1:0] sy_x;
  logic [VX-1:0] sy_aot_x;
  logic          hs_act;
  logic          vs_act;

  assign sx_x   = {1'b0, sx};
  assign sy_x   = {1'b0, sy};
  assign sx_sum = sx_x + LEAD_X;

  // Look-ahead crossing the end of the line moves to the next row,
  // and past the last row back to row 0.
  always_comb begin
    sx_aot = sx_sum[H_ADDR_WIDTH-1:0];
    sy_aot = sy;
    if (sx_sum > H_LAST_X) begin
      sx_aot = H_ADDR_WIDTH'(sx_sum - H_WHOLE_X);
      sy_aot = (sy == V_LAST) ? '0 : sy + 1'b1;
    end
  end

  assign sx_aot_x = {1'b0, sx_aot};
  assign sy_aot_x = {1'b0, sy_aot};

  assign display_enabled     = (sx_x < H_VIS_X) && (sy_x < V_VIS_X);
  assign display_enabled_aot = (sx_aot_x < H_VIS_X) && (sy_aot_x < V_VIS_X);

  assign hs_act = (sx_x >= HS_START_X) && (sx_x < HS_END_X);
  assign vs_act = (sy_x >= VS_START_X) && (sy_x < VS_END_X);
  assign hsync  = hs_act ? HS_POL : ~HS_POL;
  assign vsync  = vs_act ? VS_POL : ~VS_POL;

  assign line_stb_aot  = pix_ce && (sx_aot == '0);
  assign frame_stb_aot = line_stb_aot && (sy_aot == '0);
  assign frame_stb     = pix_ce && (sx == '0) && (sy == '0);

endmodule

// File: tb/tb_vga_timing_aot.sv
// Bench for vga_timing_aot: one default-timing instance plus three
// small-raster instances (LEAD=2, LEAD=0 with inverted polarities,
// LEAD=H_WHOLE_LINE-1) driven in lockstep and compared against a
// linear-pixel-index reference model.
module tb_vga_timing_aot;

  typedef struct {
    int hvis, hfp, hsp, hbp, vvis, vfp, vsp, vbp, lead, hpol, vpol, fcw;
  } cfg_t;

  typedef struct {
    int sx, sy, sxa, sya, de, dea, hs, vs, ls, fsa, fs, fc;
  } obs_t;

  typedef struct {
    bit r; bit c; int n; int ex; int ey; int efc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_ce = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: linear pixel index within the frame and frame count.
  int pb = 0, fb = 0;   // default raster
  int ps = 0, fsm = 0;  // small raster
  localparam int BIG_FRAME = 800 * 525;
  localparam int SM_FRAME  = 25 * 17;

  cfg_t cfg[4];

  // Default instance
  logic [9:0]  sx0, sy0, sxa0, sya0;
  logic [15:0] fc0;
  logic de0, dea0, hs0, vs0, ls0, fsa0, fs0;

  vga_timing_aot u_d0 (
    .vga_pix_clk(clk), .rst(rst), .pix_ce(pix_ce),
    .sx(sx0), .sy(sy0), .display_enabled(de0), .hsync(hs0), .vsync(vs0),
    .sx_aot(sxa0), .sy_aot(sya0), .display_enabled_aot(dea0),
    .line_stb_aot(ls0), .frame_stb_aot(fsa0), .frame_stb(fs0), .frame_cnt(fc0)
  );

  // Small instances (25 x 17 raster)
  logic [4:0] sxs[1:3], sys[1:3], sxas[1:3], syas[1:3];
  logic [2:0] fcs[1:3];
  logic des[1:3], deas[1:3], hss[1:3], vss[1:3], lss[1:3], fsas[1:3], fss[1:3];

  localparam int SM_LEAD[1:3] = '{2, 0, 24};
  localparam bit SM_POL[1:3]  = '{1'b0, 1'b1, 1'b0};

  for (genvar g = 1; g <= 3; g++) begin : g_small
    vga_timing_aot #(
      .H_VISIBLE_AREA(16), .H_FRONT_PORCH(2), .H_SYNC_PULSE(4), .H_BACK_PORCH(3),
      .V_VISIBLE_AREA(10), .V_FRONT_PORCH(2), .V_SYNC_PULSE(2), .V_BACK_PORCH(3),
      .LEAD(SM_LEAD[g]), .HS_POL(SM_POL[g]), .VS_POL(SM_POL[g]), .FRAME_CNT_W(3)
    ) u_dut (
      .vga_pix_clk(clk), .rst(rst), .pix_ce(pix_ce),
      .sx(sxs[g]), .sy(sys[g]), .display_enabled(des[g]), .hsync(hss[g]), .vsync(vss[g]),
      .sx_aot(sxas[g]), .sy_aot(syas[g]), .display_enabled_aot(deas[g]),
      .line_stb_aot(lss[g]), .frame_stb_aot(fsas[g]), .frame_stb(fss[g]), .frame_cnt(fcs[g])
    );
  end

  function automatic obs_t get_obs(int i);
    obs_t o;
    if (i == 0) begin
      o = '{int'(sx0), int'(sy0), int'(sxa0), int'(sya0), int'(de0), int'(dea0),
            int'(hs0), int'(vs0), int'(ls0), int'(fsa0), int'(fs0), int'(fc0)};
    end else begin
      o = '{int'(sxs[i]), int'(sys[i]), int'(sxas[i]), int'(syas[i]), int'(des[i]),
            int'(deas[i]), int'(hss[i]), int'(vss[i]), int'(lss[i]), int'(fsas[i]),
            int'(fss[i]), int'(fcs[i])};
    end
    return o;
  endfunction

  // Expected outputs from the raster rules: position is a linear index,
  // look-ahead is that index plus LEAD modulo the frame size.
  function automatic obs_t model(cfg_t c, int p, int fc, int ce);
    obs_t o;
    int hw = c.hvis + c.hfp + c.hsp + c.hbp;
    int vw = c.vvis + c.vfp + c.vsp + c.vbp;
    int q  = (p + c.lead) % (hw * vw);
    o.sx  = p % hw;
    o.sy  = p / hw;
    o.sxa = q % hw;
    o.sya = q / hw;
    o.de  = (o.sx < c.hvis && o.sy < c.vvis) ? 1 : 0;
    o.dea = (o.sxa < c.hvis && o.sya < c.vvis) ? 1 : 0;
    o.hs  = (o.sx >= c.hvis + c.hfp && o.sx < c.hvis + c.hfp + c.hsp) ? c.hpol : 1 - c.hpol;
    o.vs  = (o.sy >= c.vvis + c.vfp && o.sy < c.vvis + c.vfp + c.vsp) ? c.vpol : 1 - c.vpol;
    o.ls  = (ce != 0 && o.sxa == 0) ? 1 : 0;
    o.fsa = (ce != 0 && q == 0) ? 1 : 0;
    o.fs  = (ce != 0 && p == 0) ? 1 : 0;
    o.fc  = fc % (1 << c.fcw);
    return o;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare(input int i);
    obs_t o, m;
    o = get_obs(i);
    m = model(cfg[i], (i == 0) ? pb : ps, (i == 0) ? fb : fsm, int'(pix_ce));
    check($sformatf("d%0d.sx", i),   o.sx,  m.sx);
    check($sformatf("d%0d.sy", i),   o.sy,  m.sy);
    check($sformatf("d%0d.sxa", i),  o.sxa, m.sxa);
    check($sformatf("d%0d.sya", i),  o.sya, m.sya);
    check($sformatf("d%0d.de", i),   o.de,  m.de);
    check($sformatf("d%0d.dea", i),  o.dea, m.dea);
    check($sformatf("d%0d.hs", i),   o.hs,  m.hs);
    check($sformatf("d%0d.vs", i),   o.vs,  m.vs);
    check($sformatf("d%0d.ls", i),   o.ls,  m.ls);
    check($sformatf("d%0d.fsa", i),  o.fsa, m.fsa);
    check($sformatf("d%0d.fs", i),   o.fs,  m.fs);
    check($sformatf("d%0d.fc", i),   o.fc,  m.fc);
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) compare(i);
  endtask

  // Apply inputs, take one edge, advance the model, compare #1 later.
  task automatic step(input bit r, input bit c, input bit chk);
    rst = r;
    pix_ce = c;
    @(posedge clk);
    if (r) begin
      pb = 0; fb = 0; ps = 0; fsm = 0;
    end else if (c) begin
      pb++;
      if (pb == BIG_FRAME) begin pb = 0; fb++; end
      ps++;
      if (ps == SM_FRAME) begin ps = 0; fsm++; end
    end
    #1;
    if (chk) compare_all();
  endtask

  vec_t tbl[8];

  initial begin
    obs_t o, o2;
    int n, fc_before, de_cnt, hs_cnt, vs_cnt, bad_stb, fs_cnt;

    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 0, 0, 16};
    cfg[1] = '{16, 2, 4, 3, 10, 2, 2, 3, 2, 0, 0, 3};
    cfg[2] = '{16, 2, 4, 3, 10, 2, 2, 3, 0, 1, 1, 3};
    cfg[3] = '{16, 2, 4, 3, 10, 2, 2, 3, 24, 0, 0, 3};

    // {rst, ce, cycles, expected sx, sy, frame_cnt} for the LEAD=2 small raster
    tbl[0] = '{1'b1, 1'b1, 2,   0,  0,  0};
    tbl[1] = '{1'b0, 1'b1, 5,   5,  0,  0};
    tbl[2] = '{1'b0, 1'b0, 7,   5,  0,  0};
    tbl[3] = '{1'b0, 1'b1, 20,  0,  1,  0};
    tbl[4] = '{1'b0, 1'b1, 26,  1,  2,  0};
    tbl[5] = '{1'b1, 1'b0, 1,   0,  0,  0};
    tbl[6] = '{1'b0, 1'b1, 424, 24, 16, 0};
    tbl[7] = '{1'b0, 1'b1, 1,   0,  0,  1};

    // Reset, 3 cycles with pix_ce high
    repeat (3) step(1'b1, 1'b1, 1'b1);
    o = get_obs(0);
    check("rst.sx", o.sx, 0);
    check("rst.sy", o.sy, 0);
    check("rst.sx_aot", o.sxa, 2);
    check("rst.sy_aot", o.sya, 0);
    check("rst.hsync", o.hs, 1);
    check("rst.vsync", o.vs, 1);
    check("rst.frame_cnt", o.fc, 0);
    check("rst.frame_stb", o.fs, 1);
    check("rst.de", o.de, 1);
    // Still in reset: the first post-reset cycle starts from the same state
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);

    // Table-driven vectors
    for (int k = 0; k < 8; k++) begin
      repeat (tbl[k].n) step(tbl[k].r, tbl[k].c, 1'b0);
      o = get_obs(1);
      check($sformatf("tbl%0d.sx", k), o.sx, tbl[k].ex);
      check($sformatf("tbl%0d.sy", k), o.sy, tbl[k].ey);
      check($sformatf("tbl%0d.fc", k), o.fc, tbl[k].efc);
      compare_all();
    end

    // Line wrap of the look-ahead on the default raster
    step(1'b1, 1'b1, 1'b1);
    repeat (10 * 800 + 798) step(1'b0, 1'b1, 1'b0);
    compare_all();
    o = get_obs(0);
    check("lw.sx", o.sx, 798);
    check("lw.sy", o.sy, 10);
    check("lw.sx_aot", o.sxa, 0);
    check("lw.sy_aot", o.sya, 11);
    check("lw.line_stb_aot", o.ls, 1);
    step(1'b0, 1'b1, 1'b1);
    o = get_obs(0);
    check("lw1.sx", o.sx, 799);
    check("lw1.sx_aot", o.sxa, 1);
    check("lw1.sy_aot", o.sya, 11);

    // Frame wrap of the look-ahead on the small LEAD=2 raster
    n = (423 - ps + SM_FRAME) % SM_FRAME;
    repeat (n) step(1'b0, 1'b1, 1'b0);
    o = get_obs(1);
    check("fw.sx", o.sx, 23);
    check("fw.sy", o.sy, 16);
    check("fw.sx_aot", o.sxa, 0);
    check("fw.sy_aot", o.sya, 0);
    check("fw.frame_stb_aot", o.fsa, 1);
    fc_before = o.fc;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    o = get_obs(1);
    check("fw2.sx", o.sx, 0);
    check("fw2.sy", o.sy, 0);
    check("fw2.frame_stb", o.fs, 1);
    check("fw2.frame_cnt", o.fc, (fc_before + 1) % 8);

    // LEAD = H_WHOLE_LINE-1 at sx=1
    step(1'b0, 1'b1, 1'b1);
    o = get_obs(3);
    check("lmax.sx", o.sx, 1);
    check("lmax.sx_aot", o.sxa, 0);
    check("lmax.sy_aot", o.sya, o.sy + 1);

    // Full small frame: sync windows and visible-cycle count
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int k = 0; k < SM_FRAME; k++) begin
      o = get_obs(1);
      if (o.de == 1) de_cnt++;
      if (o.hs == 0) hs_cnt++;
      if (o.vs == 0) vs_cnt++;
      o2 = get_obs(2);
      check("l0.sx_aot", o2.sxa, o2.sx);
      check("l0.sy_aot", o2.sya, o2.sy);
      check("l0.de_aot", o2.dea, o2.de);
      step(1'b0, 1'b1, 1'b1);
    end
    check("frame.de_cycles", de_cnt, 16 * 10);
    check("frame.hsync_low", hs_cnt, 17 * 4);
    check("frame.vsync_low", vs_cnt, 2 * 25);

    // Clock-enable every 4th cycle
    fc_before = get_obs(1).fc;
    bad_stb = 0; fs_cnt = 0;
    for (int k = 0; k < 4 * SM_FRAME; k++) begin
      step(1'b0, (k % 4) == 3, 1'b1);
      for (int i = 0; i < 4; i++) begin
        o = get_obs(i);
        if (!pix_ce && (o.ls | o.fsa | o.fs) != 0) bad_stb++;
      end
      if (get_obs(1).fs == 1) fs_cnt++;
    end
    check("ce.strobe_without_ce", bad_stb, 0);
    check("ce.frame_stb_count", fs_cnt, 1);
    check("ce.frame_cnt", get_obs(1).fc, (fc_before + 1) % 8);

    // Mid-frame reset with pix_ce low
    repeat (37) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      o = get_obs(i);
      check($sformatf("mrst%0d.sx", i), o.sx, 0);
      check($sformatf("mrst%0d.sy", i), o.sy, 0);
      check($sformatf("mrst%0d.fc", i), o.fc, 0);
    end

    // Random enable / occasional reset against the model
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
